// File: rtl/return_stack.sv
// LIFO of return addresses for the CPU's call/return path. It replaces the single return register.
// Overflow overwrites the oldest entry in a circular way. Sticky flags record overflow and underflow.
module return_stack #(
   parameter int WIDTH = 10,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    sp;
   logic [AW-1:0]    sp_m1;
   logic [AW-1:0]    wr_addr;
   logic             ovf_set;
   logic             unf_set;

   assign sp_m1   = sp - 1'b1;
   assign empty   = (count == '0);
   assign full    = (count == {1'b1, {AW{1'b0}}});
   assign q       = empty ? '0 : mem[sp_m1];
   assign ovf_set = push & ~pop & full;
   assign unf_set = pop & empty;

   // A push together with a pop replaces the top entry. On an empty stack it acts as a plain push.
   assign wr_addr = (push && pop && !empty) ? sp_m1 : sp;

   // NOTE: the array has no reset. Entries above the top are never observed, because q is gated by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_addr] <= d;
   end

   // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               sp <= sp + 1'b1;
               if (!full) count <= count + 1'b1;
            end
            2'b01: begin
               if (!empty) begin
                  sp    <= sp_m1;
                  count <= count - 1'b1;
               end
            end
            2'b11: begin
               if (empty) begin
                  sp    <= sp + 1'b1;
                  count <= {{AW{1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
         // A new error takes priority over a clear in the same cycle.
         ovf <= ovf_set | (ovf & ~err_clr);
         unf <= unf_set | (unf & ~err_clr);
      end
   end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack. It runs a directed vector table, then the overflow and async-reset sequences.
// It ends with random traffic checked against a queue-based model.
module tb_return_stack;

   logic       clk = 1'b0;
   logic       reset, push, pop, err_clr;
   logic [9:0] d;
   logic [9:0] q;
   logic [3:0] count;
   logic       empty, full, ovf, unf;

   int n_tests = 0;
   int n_fail  = 0;

   return_stack #(.WIDTH(10), .AW(3)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d), .err_clr(err_clr),
      .q(q), .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       pop;
      logic       ec;
      logic [9:0] d;
      logic [9:0] eq;
      logic [3:0] ecnt;
      logic       eovf;
      logic       eunf;
   } vec_t;

   vec_t tbl[17];

   // Behavioural model: the back of the queue is the top of the stack.
   logic [9:0] mq[$];
   logic       movf, munf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [9:0] eq, input logic [3:0] ecnt,
                              input logic eovf, input logic eunf);
      check({tag, ".q"},     32'(q),     32'(eq));
      check({tag, ".count"}, 32'(count), 32'(ecnt));
      check({tag, ".empty"}, 32'(empty), 32'(ecnt == 4'd0));
      check({tag, ".full"},  32'(full),  32'(ecnt == 4'd8));
      check({tag, ".ovf"},   32'(ovf),   32'(eovf));
      check({tag, ".unf"},   32'(unf),   32'(eunf));
   endtask

   // Drive inputs at the falling edge. Let the rising edge commit them. Return 1 ns after that edge.
   task automatic step(input logic p, input logic po, input logic [9:0] dd, input logic ec);
      @(negedge clk);
      push = p; pop = po; d = dd; err_clr = ec;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   task automatic model_step(input logic p, input logic po, input logic [9:0] dd, input logic ec);
      logic so, su;
      so = 1'b0; su = 1'b0;
      case ({p, po})
         2'b10: begin
            if (mq.size() == 8) begin
               void'(mq.pop_front());
               so = 1'b1;
            end
            mq.push_back(dd);
         end
         2'b01: begin
            if (mq.size() == 0) su = 1'b1;
            else void'(mq.pop_back());
         end
         2'b11: begin
            if (mq.size() == 0) begin
               mq.push_back(dd);
               su = 1'b1;
            end else mq[mq.size()-1] = dd;
         end
         default: ;
      endcase
      movf = so | (movf & ~ec);
      munf = su | (munf & ~ec);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #2;
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      movf = 1'b0; munf = 1'b0;
   endtask

   initial begin
      logic p, po, ec;
      logic [9:0] dd, mtop;

      reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; d = '0;
      movf = 1'b0; munf = 1'b0;
      #12;
      check_state("reset", 10'h000, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 1'b0, 10'h3FF, 1'b0);
      check_state("idle", 10'h000, 4'd0, 1'b0, 1'b0);

      // {push, pop, err_clr, d, expected q, count, ovf, unf}
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'h011, 10'h011, 4'd1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 10'h022, 10'h022, 4'd2, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 10'h033, 10'h033, 4'd3, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h022, 4'd2, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h011, 4'd1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 4'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 4'd0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 4'd0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 10'h100, 10'h100, 4'd1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 10'h200, 10'h200, 4'd2, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 10'h2AA, 10'h2AA, 4'd2, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h100, 4'd1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 4'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 10'h155, 10'h155, 4'd1, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h155, 4'd1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 4'd0, 1'b0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].push, tbl[i].pop, tbl[i].d, tbl[i].ec);
         check_state($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ecnt, tbl[i].eovf, tbl[i].eunf);
      end

      // Fill to DEPTH, overflow once, then drain. Entry 0x001 must be lost.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
      check_state("fill8", 10'h008, 4'd8, 1'b0, 1'b0);
      step(1'b1, 1'b0, 10'h009, 1'b0);
      check_state("ovf_push", 10'h009, 4'd8, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d.top", i), 32'(q), 32'(9 - i));
         step(1'b0, 1'b1, 10'h000, 1'b0);
      end
      check_state("drained", 10'h000, 4'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 10'h000, 1'b1);
      check_state("ovf_clr", 10'h000, 4'd0, 1'b0, 1'b0);

      // Assert reset asynchronously in mid-cycle, and observe its effect before the next clock edge.
      step(1'b1, 1'b0, 10'h0A1, 1'b0);
      step(1'b1, 1'b0, 10'h0A2, 1'b0);
      step(1'b1, 1'b0, 10'h0A3, 1'b0);
      check_state("pre_async", 10'h0A3, 4'd3, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_state("async_rst", 10'h000, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 1'b0, 10'h000, 1'b0);
      check_state("post_rst", 10'h000, 4'd0, 1'b0, 1'b0);

      // Random traffic against the model. Pushes are biased, so full and overflow cases occur.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         p  = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 45);
         ec = ($urandom_range(0, 99) < 8);
         dd = 10'($urandom);
         step(p, po, dd, ec);
         model_step(p, po, dd, ec);
         mtop = (mq.size() == 0) ? 10'h000 : mq[mq.size()-1];
         check_state($sformatf("rnd%0d", i), mtop, 4'(mq.size()), movf, munf);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
